calc_seq_core: RTL and testbench

Parametrised sequential arithmetic core, successor to the 4-bit combinational adder top.
- Supports ADD, SUB, MUL and DIV on WIDTH-bit unsigned operands.
- Uses a start/busy/done handshake. MUL and DIV are iterative, one bit per cycle.
- Instantiated under the chip top-level wrapper, which maps ui_in/uio_in to operands/control and uo_out/uio_out to result/status.

---
 rtl/calc_seq_pkg.sv | 21 ++
 rtl/calc_seq_muldiv.sv | 75 +++++++
 rtl/calc_seq_core.sv | 135 +++++++++++++
 tb/tb_calc_seq_core.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_seq_pkg.sv
// Shared op encodings, FSM state type and per-op iteration count for calc_seq_core.
// CALC_SEQ_DIV_EN (optional macro) enables the divider datapath in the core and muldiv unit.
package calc_seq_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Iterative ops retire one bit per cycle; everything else needs a single RUN cycle.
   function automatic int unsigned iter_count(input logic [1:0] op, input int unsigned width);
      return ((op == OP_MUL) || (op == OP_DIV)) ? width : 1;
   endfunction

endpackage

// File: rtl/calc_seq_muldiv.sv
// Shift-add multiplier / restoring divider on one shared 2*WIDTH working register and counter.
// Loads in 1 cycle, one bit per step; divider path only exists with CALC_SEQ_DIV_EN, no backpressure.
module calc_seq_muldiv
   import calc_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   localparam int CW   = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [CW-1:0]      cnt_init,
   input  logic               is_mul,
`ifdef CALC_SEQ_DIV_EN
   input  logic               is_div,
`endif
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] acc_nxt,
   output logic               last
);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH:0]     mul_sum;
`ifdef CALC_SEQ_DIV_EN
   logic [WIDTH:0]     div_trial;
   logic [WIDTH:0]     div_diff;
`endif

   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      // Upper half accumulates the product, lower half shifts the multiplier out LSB first.
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b} : '0);
`ifdef CALC_SEQ_DIV_EN
      // Upper half is the partial remainder, lower half shifts dividend out / quotient in.
      div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_trial - {1'b0, b};
`endif
      if (load) begin
         acc_d = {{WIDTH{1'b0}}, a};
         cnt_d = cnt_init;
      end else if (step) begin
         cnt_d = cnt_q - 1'b1;
         if (is_mul) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
         end
`ifdef CALC_SEQ_DIV_EN
         else if (is_div) begin
            if (!div_diff[WIDTH]) begin
               acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   assign acc_nxt = acc_d;
   assign last    = (cnt_q == CW'(1));

endmodule

// File: rtl/calc_seq_core.sv
// Sequential ADD/SUB/MUL/DIV core: ADD/SUB/div-by-0 done at T+2, MUL/DIV at T+WIDTH+1 (enabled cycles).
// start ignored while busy, ena=0 freezes all state; DIV needs CALC_SEQ_DIV_EN, else op=11 flags err.
module calc_seq_core
   import calc_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               err
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               err_q, err_d;

   logic               md_load, md_step, md_is_mul, md_last;
   logic [CW-1:0]      cnt_init;
   logic [2*WIDTH-1:0] md_acc_nxt;
   logic [WIDTH:0]     add_sum, sub_diff;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      err_d    = err_q;
      md_load  = 1'b0;
      md_step  = 1'b0;
      add_sum  = {1'b0, a_q} + {1'b0, b_q};
      sub_diff = {1'b0, a_q} - {1'b0, b_q};
      cnt_init = CW'(iter_count(op, WIDTH));
`ifdef CALC_SEQ_DIV_EN
      if ((op == OP_DIV) && (b == '0)) cnt_init = CW'(1);
`else
      if (op == OP_DIV) cnt_init = CW'(1);
`endif
      if (ena) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = RUN;
                  op_d    = op;
                  a_d     = a;
                  b_d     = b;
                  md_load = 1'b1;
               end
            end
            RUN: begin
               md_step = 1'b1;
               if (md_last) begin
                  state_d = DONE;
                  err_d   = 1'b0;
                  case (op_q)
                     OP_ADD:  result_d = {{(WIDTH-1){1'b0}}, add_sum};
                     // Bit WIDTH of the widened difference is the borrow.
                     OP_SUB:  result_d = {{(WIDTH-1){1'b0}}, sub_diff};
                     OP_MUL:  result_d = md_acc_nxt;
                     default: begin
`ifdef CALC_SEQ_DIV_EN
                        if (b_q == '0) begin
                           err_d    = 1'b1;
                           result_d = {a_q, {WIDTH{1'b1}}};
                        end else begin
                           result_d = md_acc_nxt;
                        end
`else
                        err_d    = 1'b1;
                        result_d = '0;
`endif
                     end
                  endcase
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= OP_ADD;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   assign md_is_mul = (op_q == OP_MUL);

   calc_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (md_load),
      .step     (md_step),
      .cnt_init (cnt_init),
      .is_mul   (md_is_mul),
`ifdef CALC_SEQ_DIV_EN
      .is_div   ((op_q == OP_DIV) && (b_q != '0)),
`endif
      .a        (a),
      .b        (b_q),
      .acc_nxt  (md_acc_nxt),
      .last     (md_last)
   );

   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign err    = err_q;

endmodule

// File: tb/tb_calc_seq_core.sv
// Randomized and directed bench for calc_seq_core (WIDTH=4) against an arithmetic reference model.
module tb_calc_seq_core;

   localparam int W = 4;

   logic           clk;
   logic           rst_n;
   logic           ena;
   logic           start;
   logic [1:0]     op;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] result;
   logic           err;

   int             checks;
   int             errors;
   logic [2*W-1:0] last_res;
   logic           last_err;

   calc_seq_core #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: expected result, err flag and enabled-edge count from acceptance to done.
   function automatic void model(input int o, input int x, input int y,
                                 output logic [2*W-1:0] r, output logic e, output int lat);
      e   = 1'b0;
      lat = 1;
      r   = '0;
      case (o)
         0: r = 8'(x + y);
         1: r = 8'(((x < y) ? 16 : 0) + ((x - y + 16) % 16));
         2: begin
            r   = 8'(x * y);
            lat = W;
         end
         default: begin
`ifdef CALC_SEQ_DIV_EN
            if (y == 0) begin
               e = 1'b1;
               r = 8'(x * 16 + 15);
            end else begin
               r   = 8'((x % y) * 16 + (x / y));
               lat = W;
            end
`else
            e = 1'b1;
            r = '0;
`endif
         end
      endcase
   endfunction

   task automatic exec(input int o, input int x, input int y, input bit spam,
                       input bit stall, input bit hold_done, input string name);
      logic [2*W-1:0] exp_r;
      logic           exp_e;
      int             exp_lat;
      int             edges;
      int             cyc;
      bit             stalled;
      model(o, x, y, exp_r, exp_e, exp_lat);
      @(negedge clk);
      ena   = 1'b1;
      op    = 2'(o);
      a     = 4'(x);
      b     = 4'(y);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = spam;
      op    = 2'($urandom_range(0, 3));
      a     = 4'($urandom_range(0, 15));
      b     = 4'($urandom_range(0, 15));
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s busy/done after accept: got %b/%b want 1/0", name, busy, done);
      end
      checks++;
      if (result !== last_res || err !== last_err) begin
         errors++;
         $display("FAIL %s hold prev result: got %h/%b want %h/%b", name, result, err, last_res, last_err);
      end
      edges   = 0;
      cyc     = 0;
      stalled = 1'b0;
      while (!done && edges < 60) begin
         if (stall && !stalled && edges == 2) begin
            stalled = 1'b1;
            ena     = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(posedge clk);
               @(negedge clk);
               cyc++;
            end
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
               errors++;
               $display("FAIL %s stall hold: busy/done %b/%b want 1/0", name, busy, done);
            end
            ena = 1'b1;
         end
         @(posedge clk);
         edges++;
         cyc++;
         @(negedge clk);
         if (spam) begin
            op = 2'($urandom_range(0, 3));
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
         end
      end
      start = 1'b0;
      checks++;
      if (edges !== exp_lat || cyc !== exp_lat + (stall ? 3 : 0)) begin
         errors++;
         $display("FAIL %s latency: got %0d edges %0d cycles want %0d", name, edges, cyc, exp_lat);
      end
      checks++;
      if (result !== exp_r || err !== exp_e) begin
         errors++;
         $display("FAIL %s result: got %h err %b want %h err %b", name, result, err, exp_r, exp_e);
      end
      last_res = exp_r;
      last_err = exp_e;
      if (hold_done) begin
         ena = 1'b0;
         repeat (2) begin
            @(posedge clk);
            @(negedge clk);
         end
         checks++;
         if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done hold with ena=0: got %b want 1", name, done);
         end
         ena = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s done width: done/busy %b/%b want 0/0", name, done, busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ena   = 1'b1;
      start = 1'b1;
      op    = 2'd2;
      a     = 4'hF;
      b     = 4'hF;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || result !== 8'h00) begin
         errors++;
         $display("FAIL reset: busy %b done %b err %b result %h want 0 0 0 00", busy, done, err, result);
      end
      start    = 1'b0;
      rst_n    = 1'b1;
      last_res = '0;
      last_err = 1'b0;
   endtask

   task automatic test_directed();
      int t_op[9] = '{0, 1, 1, 2, 2, 3, 3, 0, 3};
      int t_a[9]  = '{9, 3, 5, 15, 0, 13, 7, 15, 15};
      int t_b[9]  = '{8, 5, 3, 15, 9, 4, 0, 15, 1};
      for (int i = 0; i < 9; i++) begin
         exec(t_op[i], t_a[i], t_b[i], 1'b0, 1'b0, 1'b0, $sformatf("directed%0d", i));
      end
   endtask

   task automatic test_back_to_back();
      exec(2, 11, 13, 1'b1, 1'b0, 1'b0, "spam_mul");
      exec(3, 14, 3, 1'b1, 1'b0, 1'b0, "spam_div");
   endtask

   task automatic test_stall();
      exec(2, 15, 15, 1'b0, 1'b1, 1'b1, "stall_mul");
      exec(1, 2, 9, 1'b0, 1'b0, 1'b1, "hold_sub");
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         exec(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'b0, 1'b0, $sformatf("random%0d", i));
      end
   endtask

   task automatic test_reset_mid();
      exec(0, 9, 8, 1'b0, 1'b0, 1'b0, "pre_reset_add");
      @(negedge clk);
      op    = 2'd2;
      a     = 4'd7;
      b     = 4'd9;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || result !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid: busy %b done %b err %b result %h want 0 0 0 00", busy, done, err, result);
      end
      @(negedge clk);
      rst_n    = 1'b1;
      last_res = '0;
      last_err = 1'b0;
      exec(0, 1, 1, 1'b0, 1'b0, 1'b0, "post_reset_add");
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      last_res = '0;
      last_err = 1'b0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
